// File: rtl/pin_collision.sv
// Pin collision resolver: scans ten pins against a snapshotted ball position,
// computes outgoing velocities for newly struck pins and keeps a sticky hit mask.
module pin_collision #(
  parameter logic [33:0] HIT_R2 = 34'd28224,
  parameter int unsigned N_PINS = 10
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           check_in,
  input  logic                           clear_in,
  input  logic [15:0]                    ball_x,
  input  logic [15:0]                    ball_y,
  input  logic [15:0]                    speed_x,
  input  logic [15:0]                    speed_y,
  input  logic [N_PINS-1:0][15:0]        pins_x,
  input  logic [N_PINS-1:0][15:0]        pins_y,
  output logic [N_PINS-1:0][15:0]        pins_vx_out,
  output logic [N_PINS-1:0][15:0]        pins_vy_out,
  output logic [N_PINS-1:0]              pins_hit_out,
  output logic                           valid_out,
  output logic                           busy_out
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned POS_W = 16;
  localparam int unsigned DIF_W = POS_W + 1;
  localparam int unsigned SUM_W = POS_W + 2;
  localparam int unsigned SQ_W  = 34;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        drain_q, drain_d;

  logic [POS_W-1:0]            bx_q, bx_d, by_q, by_d;
  logic [POS_W-1:0]            sx_q, sx_d, sy_q, sy_d;
  logic [N_PINS-1:0][POS_W-1:0] px_q, px_d, py_q, py_d;

  logic                        s1_vld_q, s1_vld_d;
  logic [IDX_W-1:0]            s1_idx_q, s1_idx_d;
  logic signed [DIF_W-1:0]     s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;

  logic [N_PINS-1:0][POS_W-1:0] vx_q, vx_d, vy_q, vy_d;
  logic [N_PINS-1:0]           hit_q, hit_d;
  logic                        valid_q, valid_d;
  logic                        busy_q, busy_d;

  logic signed [SQ_W-1:0]      dx_w_c, dy_w_c, sq_x_c, sq_y_c;
  logic [SQ_W-1:0]             d2_c;
  logic signed [SUM_W-1:0]     half_x_c, half_y_c, sum_x_c, sum_y_c;
  logic                        new_hit_c;

  // Clamp an 18-bit signed sum to the signed 16-bit range.
  function automatic logic [POS_W-1:0] sat16(input logic signed [SUM_W-1:0] s);
    if (s > 18'sd32767)       return 16'h7fff;
    else if (s < -18'sd32768) return 16'h8000;
    else                      return s[POS_W-1:0];
  endfunction

  // Stage 2: squared distance, threshold test and velocity for the staged pin.
  always_comb begin
    dx_w_c    = {{(SQ_W-DIF_W){s1_dx_q[DIF_W-1]}}, s1_dx_q};
    dy_w_c    = {{(SQ_W-DIF_W){s1_dy_q[DIF_W-1]}}, s1_dy_q};
    sq_x_c    = dx_w_c * dx_w_c;
    sq_y_c    = dy_w_c * dy_w_c;
    d2_c      = sq_x_c + sq_y_c;
    half_x_c  = {{3{sx_q[POS_W-1]}}, sx_q[POS_W-1:1]};
    half_y_c  = {{3{sy_q[POS_W-1]}}, sy_q[POS_W-1:1]};
    sum_x_c   = half_x_c + {s1_dx_q[DIF_W-1], s1_dx_q};
    sum_y_c   = half_y_c + {s1_dy_q[DIF_W-1], s1_dy_q};
    new_hit_c = s1_vld_q && !hit_q[s1_idx_q] && (d2_c <= HIT_R2);
  end

  // Next-state: FSM, snapshot, stage-1 issue and write-back.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    bx_d     = bx_q;
    by_d     = by_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    px_d     = px_q;
    py_d     = py_q;
    s1_vld_d = 1'b0;
    s1_idx_d = s1_idx_q;
    s1_dx_d  = s1_dx_q;
    s1_dy_d  = s1_dy_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    hit_d    = hit_q;

    case (state_q)
      S_IDLE: begin
        if (check_in) begin
          state_d = S_SCAN;
          idx_d   = '0;
          bx_d    = ball_x;
          by_d    = ball_y;
          sx_d    = speed_x;
          sy_d    = speed_y;
          px_d    = pins_x;
          py_d    = pins_y;
        end
      end
      S_SCAN: begin
        s1_vld_d = 1'b1;
        s1_idx_d = idx_q;
        s1_dx_d  = {1'b0, px_q[idx_q]} - {1'b0, bx_q};
        s1_dy_d  = {1'b0, py_q[idx_q]} - {1'b0, by_q};
        if (idx_q == IDX_W'(N_PINS - 1)) begin
          state_d = S_DRAIN;
          idx_d   = '0;
          drain_d = 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (new_hit_c) begin
      hit_d[s1_idx_q] = 1'b1;
      vx_d[s1_idx_q]  = sat16(sum_x_c);
      vy_d[s1_idx_q]  = sat16(sum_y_c);
    end

    // Clear wins over everything, including a same-cycle request.
    if (clear_in) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      drain_d  = 1'b0;
      s1_vld_d = 1'b0;
      hit_d    = '0;
      vx_d     = '0;
      vy_d     = '0;
    end

    valid_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      drain_q  <= 1'b0;
      bx_q     <= '0;
      by_q     <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      px_q     <= '0;
      py_q     <= '0;
      s1_vld_q <= 1'b0;
      s1_idx_q <= '0;
      s1_dx_q  <= '0;
      s1_dy_q  <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      hit_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      px_q     <= px_d;
      py_q     <= py_d;
      s1_vld_q <= s1_vld_d;
      s1_idx_q <= s1_idx_d;
      s1_dx_q  <= s1_dx_d;
      s1_dy_q  <= s1_dy_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      hit_q    <= hit_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign pins_vx_out  = vx_q;
  assign pins_vy_out  = vy_q;
  assign pins_hit_out = hit_q;
  assign valid_out    = valid_q;
  assign busy_out     = busy_q;

endmodule

// File: tb/tb_pin_collision.sv
// Directed bench for pin_collision: one task per scenario with hand-computed results.
module tb_pin_collision;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               check_in, clear_in;
  logic [15:0]        ball_x, ball_y, speed_x, speed_y;
  logic [9:0][15:0]   pins_x, pins_y;
  logic [9:0][15:0]   pins_vx_out, pins_vy_out;
  logic [9:0]         pins_hit_out;
  logic               valid_out, busy_out;
  logic [9:0][15:0]   sat_vx, sat_vy;
  logic [9:0]         sat_hit;
  logic               sat_valid, sat_busy;

  int n_vec = 0;
  int n_err = 0;

  pin_collision dut (
    .clk_in(clk_in), .rst_in(rst_in), .check_in(check_in), .clear_in(clear_in),
    .ball_x(ball_x), .ball_y(ball_y), .speed_x(speed_x), .speed_y(speed_y),
    .pins_x(pins_x), .pins_y(pins_y),
    .pins_vx_out(pins_vx_out), .pins_vy_out(pins_vy_out),
    .pins_hit_out(pins_hit_out), .valid_out(valid_out), .busy_out(busy_out)
  );

  // Wide threshold instance so every pin hits and saturation can be reached.
  pin_collision #(.HIT_R2(34'h2_0000_0000)) dut_sat (
    .clk_in(clk_in), .rst_in(rst_in), .check_in(check_in), .clear_in(clear_in),
    .ball_x(ball_x), .ball_y(ball_y), .speed_x(speed_x), .speed_y(speed_y),
    .pins_x(pins_x), .pins_y(pins_y),
    .pins_vx_out(sat_vx), .pins_vy_out(sat_vy),
    .pins_hit_out(sat_hit), .valid_out(sat_valid), .busy_out(sat_busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_clear();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
  endtask

  task automatic setup_single();
    ball_x = 16'd1000; ball_y = 16'd1000;
    speed_x = 16'd0;   speed_y = 16'd400;
    pins_x = '0; pins_y = '0;
    pins_x[0] = 16'd1100; pins_y[0] = 16'd1050;
  endtask

  // Issue one request and watch 16 cycles; lat is the cycle of the first valid.
  task automatic run_scan(output int lat, output int nv);
    lat = -1; nv = 0;
    check_in = 1'b1;
    tick();
    check_in = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (valid_out) begin
        nv++;
        if (lat < 0) lat = c;
      end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; check_in = 1'b0; clear_in = 1'b0;
    setup_single();
    tick(); tick();
    n_vec++;
    if ({pins_hit_out, valid_out, busy_out} !== 12'd0 || pins_vx_out !== '0 || pins_vy_out !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: hit=%b valid=%b busy=%b, required all zero", pins_hit_out, valid_out, busy_out);
    end
    rst_in = 1'b0;
    tick();
    n_vec++;
    if (busy_out !== 1'b0 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: busy=%b valid=%b, required 0 0", busy_out, valid_out);
    end
  endtask

  task automatic test_single_hit();
    int lat, nv;
    setup_single();
    run_scan(lat, nv);
    n_vec++;
    if (lat !== 12 || nv !== 1) begin
      n_err++;
      $display("FAIL single_latency: lat=%0d count=%0d, required 12 1", lat, nv);
    end
    n_vec++;
    if (pins_hit_out !== 10'b0000000001) begin
      n_err++;
      $display("FAIL single_mask: %b, required 0000000001", pins_hit_out);
    end
    n_vec++;
    if (pins_vx_out[0] !== 16'd100 || pins_vy_out[0] !== 16'd250) begin
      n_err++;
      $display("FAIL single_vel: (%0d,%0d), required (100,250)", $signed(pins_vx_out[0]), $signed(pins_vy_out[0]));
    end
    n_vec++;
    if (pins_vx_out[9:1] !== '0 || pins_vy_out[9:1] !== '0) begin
      n_err++;
      $display("FAIL single_others: vx=%h vy=%h, required 0", pins_vx_out[9:1], pins_vy_out[9:1]);
    end
  endtask

  task automatic test_threshold();
    int lat, nv;
    do_clear();
    ball_x = 16'd1000; ball_y = 16'd1000;
    speed_x = 16'd10;  speed_y = 16'd0;
    pins_x = '0; pins_y = '0;
    pins_x[3] = 16'd1168; pins_y[3] = 16'd1000;
    pins_x[4] = 16'd1169; pins_y[4] = 16'd1000;
    run_scan(lat, nv);
    n_vec++;
    if (pins_hit_out !== 10'b0000001000) begin
      n_err++;
      $display("FAIL thresh_mask: %b, required 0000001000", pins_hit_out);
    end
    n_vec++;
    if (pins_vx_out[3] !== 16'd173 || pins_vy_out[3] !== 16'd0) begin
      n_err++;
      $display("FAIL thresh_vel3: (%0d,%0d), required (173,0)", $signed(pins_vx_out[3]), $signed(pins_vy_out[3]));
    end
    n_vec++;
    if (pins_vx_out[4] !== 16'd0 || pins_vy_out[4] !== 16'd0) begin
      n_err++;
      $display("FAIL thresh_vel4: (%0d,%0d), required (0,0)", $signed(pins_vx_out[4]), $signed(pins_vy_out[4]));
    end
  endtask

  task automatic test_sticky();
    int lat, nv;
    do_clear();
    setup_single();
    pins_x[1] = 16'd2000; pins_y[1] = 16'd2000;
    run_scan(lat, nv);
    n_vec++;
    if (pins_hit_out !== 10'b0000000001) begin
      n_err++;
      $display("FAIL sticky_first_mask: %b, required 0000000001", pins_hit_out);
    end
    ball_x = 16'd2000; ball_y = 16'd2000; speed_x = 16'd100; speed_y = 16'd0;
    run_scan(lat, nv);
    n_vec++;
    if (pins_hit_out !== 10'b0000000011) begin
      n_err++;
      $display("FAIL sticky_mask: %b, required 0000000011", pins_hit_out);
    end
    n_vec++;
    if (pins_vx_out[0] !== 16'd100 || pins_vy_out[0] !== 16'd250) begin
      n_err++;
      $display("FAIL sticky_pin0_held: (%0d,%0d), required (100,250)", $signed(pins_vx_out[0]), $signed(pins_vy_out[0]));
    end
    n_vec++;
    if (pins_vx_out[1] !== 16'd50 || pins_vy_out[1] !== 16'd0) begin
      n_err++;
      $display("FAIL sticky_pin1: (%0d,%0d), required (50,0)", $signed(pins_vx_out[1]), $signed(pins_vy_out[1]));
    end
  endtask

  task automatic test_saturation();
    int lat, nv;
    do_clear();
    ball_x = 16'd30000; ball_y = 16'd30000;
    speed_x = 16'd32766; speed_y = 16'hfe70;           // -400
    pins_x = '0; pins_y = '0;
    pins_x[0] = 16'd60000; pins_y[0] = 16'd29950;      // dx=+30000 dy=-50
    run_scan(lat, nv);
    n_vec++;
    if (sat_vx[0] !== 16'h7fff) begin
      n_err++;
      $display("FAIL sat_pos_vx: %0d, required 32767", $signed(sat_vx[0]));
    end
    n_vec++;
    if (sat_vy[0] !== 16'hff06) begin
      n_err++;
      $display("FAIL sat_neg_vy: %0d, required -250", $signed(sat_vy[0]));
    end
    n_vec++;
    if (pins_hit_out !== 10'd0) begin
      n_err++;
      $display("FAIL sat_normal_miss: %b, required 0000000000", pins_hit_out);
    end
    do_clear();
    speed_x = 16'h8000; speed_y = 16'd0;
    pins_x[1] = 16'd0; pins_y[1] = 16'd30000;          // dx=-30000 dy=0
    run_scan(lat, nv);
    n_vec++;
    if (sat_vx[1] !== 16'h8000 || sat_vy[1] !== 16'd0) begin
      n_err++;
      $display("FAIL sat_neg_vx: (%0d,%0d), required (-32768,0)", $signed(sat_vx[1]), $signed(sat_vy[1]));
    end
    n_vec++;
    if (sat_vx[0] !== 16'd13616 || sat_vy[0] !== 16'hffce) begin
      n_err++;
      $display("FAIL sat_mixed: (%0d,%0d), required (13616,-50)", $signed(sat_vx[0]), $signed(sat_vy[0]));
    end
    do_clear();
  endtask

  task automatic test_busy_ignore();
    int lat, nv;
    logic b1, b14;
    do_clear();
    setup_single();
    lat = -1; nv = 0; b1 = 1'b0; b14 = 1'b1;
    check_in = 1'b1;
    tick();
    for (int c = 1; c <= 28; c++) begin
      check_in = (c == 3 || c == 12 || c == 13);
      tick();
      if (valid_out) begin
        nv++;
        if (lat < 0) lat = c;
      end
      if (c == 1)  b1 = busy_out;
      if (c == 14) b14 = busy_out;
    end
    check_in = 1'b0;
    n_vec++;
    if (nv !== 1 || lat !== 12) begin
      n_err++;
      $display("FAIL busy_ignore: valid count=%0d lat=%0d, required 1 12", nv, lat);
    end
    n_vec++;
    if (b1 !== 1'b1 || b14 !== 1'b0) begin
      n_err++;
      $display("FAIL busy_window: busy@1=%b busy@14=%b, required 1 0", b1, b14);
    end
  endtask

  task automatic test_clear_mid();
    int nv;
    nv = 0;
    check_in = 1'b1;
    tick();
    check_in = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    n_vec++;
    if (busy_out !== 1'b0 || pins_hit_out !== 10'd0 || pins_vx_out !== '0) begin
      n_err++;
      $display("FAIL clear_mid: busy=%b hit=%b, required 0 0000000000", busy_out, pins_hit_out);
    end
    for (int c = 0; c < 16; c++) begin
      tick();
      if (valid_out) nv++;
    end
    n_vec++;
    if (nv !== 0) begin
      n_err++;
      $display("FAIL clear_no_valid: valid count=%0d, required 0", nv);
    end
  endtask

  task automatic test_clear_check();
    int lat, nv;
    run_scan(lat, nv);
    clear_in = 1'b1; check_in = 1'b1;
    tick();
    clear_in = 1'b0; check_in = 1'b0;
    nv = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (valid_out || busy_out) nv++;
    end
    n_vec++;
    if (nv !== 0 || pins_hit_out !== 10'd0) begin
      n_err++;
      $display("FAIL clear_beats_check: busy/valid cycles=%0d hit=%b, required 0 0000000000", nv, pins_hit_out);
    end
  endtask

  task automatic test_async_reset();
    int nv;
    nv = 0;
    check_in = 1'b1;
    tick();
    check_in = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    n_vec++;
    if (pins_hit_out !== 10'b0000000001 || busy_out !== 1'b1) begin
      n_err++;
      $display("FAIL areset_pre: hit=%b busy=%b, required 0000000001 1", pins_hit_out, busy_out);
    end
    #2 rst_in = 1'b1;
    #1;
    n_vec++;
    if (pins_hit_out !== 10'd0 || busy_out !== 1'b0 || valid_out !== 1'b0 || pins_vy_out !== '0) begin
      n_err++;
      $display("FAIL areset_immediate: hit=%b busy=%b valid=%b, required all zero", pins_hit_out, busy_out, valid_out);
    end
    tick();
    rst_in = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (valid_out) nv++;
    end
    n_vec++;
    if (nv !== 0) begin
      n_err++;
      $display("FAIL areset_no_valid: valid count=%0d, required 0", nv);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nv;
    do_clear();
    setup_single();
    check_in = 1'b1;
    tick();
    check_in = 1'b0;
    for (int c = 1; c <= 13; c++) tick();
    ball_x = 16'd2000; ball_y = 16'd2000;
    pins_x[1] = 16'd2000; pins_y[1] = 16'd2000;
    run_scan(lat, nv);
    n_vec++;
    if (lat !== 12 || nv !== 1) begin
      n_err++;
      $display("FAIL b2b_latency: lat=%0d count=%0d, required 12 1", lat, nv);
    end
    n_vec++;
    if (pins_hit_out !== 10'b0000000011 || pins_vx_out[1] !== 16'd0 || pins_vy_out[1] !== 16'd200) begin
      n_err++;
      $display("FAIL b2b_result: hit=%b pin1=(%0d,%0d), required 0000000011 (0,200)",
               pins_hit_out, $signed(pins_vx_out[1]), $signed(pins_vy_out[1]));
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_threshold();
    test_sticky();
    test_saturation();
    test_busy_ignore();
    test_clear_mid();
    test_clear_check();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
